mpc_dot_acc_rnd: RTL

//  Downstream stage of the signed 21x15->36 DSP multiplier in the MPC datapath.

---
 rtl/mpc_dot_acc_rnd.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mpc_dot_acc_rnd.sv
// Dot-product accumulate/round/saturate stage behind the 21x15 DSP multiplier.
// Latency: one ce-qualified clk from the row's last accepted term to out_valid.
// Backpressure: in_ready = ce & (~out_valid | out_ready); one result buffered.
// Build option: define MPC_DOT_SAT_EN to saturate results and drive ovf.
// Without it, results wrap in two's complement and ovf is tied low.
module mpc_dot_acc_rnd #(
  parameter int DIN_WIDTH  = 36,
  parameter int ACC_WIDTH  = 44,
  parameter int DOUT_WIDTH = 21,
  parameter int FRAC_SHIFT = 14,
  parameter int MAX_TERMS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic [DIN_WIDTH-1:0]  din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  len_err
);

  // Term counter must hold MAX_TERMS itself for the forced-close compare.
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  // Width of the shifted sum: one guard bit above the accumulator, minus
  // the fraction bits dropped by the shift.
  localparam int RW = ACC_WIDTH + 1 - FRAC_SHIFT;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(MAX_TERMS);
  // Half an output LSB, added before truncation for round-half-up.
  localparam logic [ACC_WIDTH:0] RND_HALF  = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [ACC_WIDTH-1:0]   din_ext;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   accept;
  logic                   close_row;
  logic                   forced_close;
  logic [ACC_WIDTH:0]     sum_rnd;
  logic signed [RW-1:0]   r;
  logic [DOUT_WIDTH-1:0]  res;
  logic                   rnd_unused;

  // ---------------------------------------------------------------------
  // Handshake and row bookkeeping
  // ---------------------------------------------------------------------

  // A term can enter only when the output slot is free or draining this cycle.
  assign in_ready = ce & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Products are signed; widen into the accumulator domain.
  assign din_ext  = {{(ACC_WIDTH - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};

  // The first term of a row loads rather than adds, so the accumulator never
  // needs a separate clear cycle between back-to-back rows.
  assign acc_next = (state == IDLE) ? din_ext : (acc + din_ext);
  assign cnt_next = (state == IDLE) ? CNT_ONE : (cnt + CNT_ONE);

  // A row closes on in_last or when it reaches MAX_TERMS; the latter also
  // covers MAX_TERMS==1 from IDLE because cnt_next is 1 there.
  assign close_row    = accept & (in_last | (cnt_next == CNT_LIMIT));
  assign forced_close = close_row & ~in_last;

  // ---------------------------------------------------------------------
  // Rounding: add half an LSB, then an arithmetic shift is just dropping the
  // low FRAC_SHIFT bits of the sign-extended sum.
  // ---------------------------------------------------------------------
  assign sum_rnd    = {acc_next[ACC_WIDTH-1], acc_next} + RND_HALF;
  assign r          = sum_rnd[ACC_WIDTH:FRAC_SHIFT];
  assign rnd_unused = ^sum_rnd[FRAC_SHIFT-1:0];

`ifdef MPC_DOT_SAT_EN
  // Largest and smallest values representable in DOUT_WIDTH bits, in the
  // wider shifted-sum domain.
  localparam logic signed [RW-1:0] R_MAX =
    {{(RW - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

  logic hi_clamp;
  logic lo_clamp;
  logic clamp;
  logic ovf_q;

  assign hi_clamp = (r > R_MAX);
  assign lo_clamp = (r < R_MIN);
  assign clamp    = hi_clamp | lo_clamp;

  // Select clamped extreme or the in-range low bits of the rounded sum.
  always_comb begin
    res = r[DOUT_WIDTH-1:0];
    if (hi_clamp) begin
      res = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
    end else if (lo_clamp) begin
      res = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};
    end
  end

  // Sticky record that some emitted result was clamped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (close_row && clamp) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic wrap_unused;

  // Plain two's-complement wrap: keep the low result bits only.
  assign res         = r[DOUT_WIDTH-1:0];
  assign wrap_unused = ^r[RW-1:DOUT_WIDTH];
  assign ovf         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Row FSM
  // ---------------------------------------------------------------------

  // State register; only an accepted term (which implies ce) moves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: closing returns to IDLE, any other accepted term is mid-row.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = close_row ? IDLE : ACC;
    end
  end

  // Accumulator and term count; cleared on close so the next row starts clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (close_row) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output slot
  // ---------------------------------------------------------------------

  // Load a result on close; otherwise drain on handshake. A close can only
  // happen while the slot is free or being drained, so nothing is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout      <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      if (close_row) begin
        dout      <= res;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky flag for a row that ran to MAX_TERMS without in_last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_err <= 1'b0;
    end else if (forced_close) begin
      len_err <= 1'b1;
    end
  end

endmodule
